// File: rtl/tc_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Module : tc_pkg                                                   |
// | Brief  : Shared constants, FSM states and helpers for tc_adc_spi  |
// | Rev    : 1.0                                                      |
// +------------------------------------------------------------------+
package tc_pkg;

  localparam int         TC_CODE_W          = 10;
  localparam int         TC_FRAME_SCLKS     = 16;
  localparam logic [4:0] TC_DATA_FIRST_EDGE = 5'd4;
  localparam logic [4:0] TC_DATA_LAST_EDGE  = 5'd13;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_PUBLISH  = 3'd4
  } tc_state_e;

  // Edge numbers are 1-based SCLK rising edges within a frame.
  function automatic logic is_data_edge(input logic [4:0] edge_num);
    return (edge_num >= TC_DATA_FIRST_EDGE) && (edge_num <= TC_DATA_LAST_EDGE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tc_spi_clkgen.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Module : tc_spi_clkgen                                            |
// | Brief  : Half-period tick divider and SCLK toggle / rise strobe   |
// | Rev    : 1.0                                                      |
// +------------------------------------------------------------------+
module tc_spi_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_toggle_en,
  output logic o_tick,
  output logic o_sclk,
  output logic o_rise
);

  localparam int             CNT_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sclk;
  logic             w_tick;

  assign w_tick = i_run && (r_cnt == c_cnt_last);

  // Held cleared outside a frame so the first half-period is always full length.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_run) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick && i_toggle_en) begin
        r_sclk <= ~r_sclk;
      end
    end
  end

  assign o_tick = w_tick;
  assign o_sclk = r_sclk;
  assign o_rise = w_tick && i_toggle_en && !r_sclk;

endmodule
`default_nettype wire

// File: rtl/tc_adc_spi.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Module : tc_adc_spi                                               |
// | Brief  : Periodic 16-SCLK read of a 10-bit serial ADC; optional   |
// |          frame averaging when TC_ADC_AVG_EN is defined            |
// | Rev    : 1.0                                                      |
// +------------------------------------------------------------------+
module tc_adc_spi
  import tc_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int AVG_LOG2      = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  output logic                 o_spi_csn,
  output logic                 o_spi_sclk,
  input  logic                 i_spi_miso,
  output logic [TC_CODE_W-1:0] o_code,
  output logic                 o_valid,
  output logic                 o_busy
);

  localparam int               TMR_W       = $clog2(SAMPLE_PERIOD);
  localparam logic [TMR_W-1:0] c_tmr_last  = TMR_W'(SAMPLE_PERIOD - 1);
  localparam logic [5:0]       c_last_half = 6'(2 * TC_FRAME_SCLKS);

  if (CLK_DIV < 1 || AVG_LOG2 < 0) begin : g_bad_cfg
    $error("tc_adc_spi: CLK_DIV must be >= 1 and AVG_LOG2 >= 0");
  end

  tc_state_e            r_state;
  logic                 r_csn;
  logic                 r_busy;
  logic                 r_valid;
  logic [TC_CODE_W-1:0] r_code;
  logic [TC_CODE_W-1:0] r_shift;
  logic [5:0]           r_half;
  logic [TMR_W-1:0]     r_tmr;

  logic w_fire;
  logic w_start;
  logic w_tick;
  logic w_rise;
  logic w_sclk;
  logic w_toggle_en;

`ifdef TC_ADC_AVG_EN
  localparam int                   ACC_W      = TC_CODE_W + AVG_LOG2;
  localparam int                   AVG_CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [AVG_CNT_W-1:0] c_avg_last = AVG_CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]     r_acc;
  logic [ACC_W-1:0]     w_sum;
  logic [AVG_CNT_W-1:0] r_avg_cnt;

  assign w_sum = r_acc + ACC_W'(r_shift);
`endif

  // Timer saturates once fired, so an expiry during a frame stays pending.
  assign w_fire      = (r_tmr == c_tmr_last);
  assign w_start     = (r_state == ST_IDLE) && i_en && w_fire;
  assign w_toggle_en = (r_state == ST_SHIFT) && (r_half != c_last_half);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmr <= '0;
    end else if (!i_en || w_start) begin
      r_tmr <= '0;
    end else if (!w_fire) begin
      r_tmr <= r_tmr + 1'b1;
    end
  end

  tc_spi_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_run       (r_busy),
    .i_toggle_en (w_toggle_en),
    .o_tick      (w_tick),
    .o_sclk      (w_sclk),
    .o_rise      (w_rise)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_csn     <= 1'b1;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_code    <= '0;
      r_shift   <= '0;
      r_half    <= '0;
`ifdef TC_ADC_AVG_EN
      r_acc     <= '0;
      r_avg_cnt <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
`ifdef TC_ADC_AVG_EN
          if (!i_en) begin
            r_acc     <= '0;
            r_avg_cnt <= '0;
          end
`endif
          if (w_start) begin
            r_state <= ST_CS_SETUP;
            r_csn   <= 1'b0;
            r_busy  <= 1'b1;
            r_half  <= '0;
          end
        end
        ST_CS_SETUP: begin
          if (w_tick) begin
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // r_half counts toggles; even values are rising edges, edge number = r_half/2 + 1.
          if (w_rise && is_data_edge(r_half[5:1] + 5'd1)) begin
            r_shift <= {r_shift[TC_CODE_W-2:0], i_spi_miso};
          end
          if (w_tick) begin
            if (r_half == c_last_half) begin
              r_state <= ST_CS_HOLD;
              r_csn   <= 1'b1;
            end else begin
              r_half <= r_half + 1'b1;
            end
          end
        end
        ST_CS_HOLD: begin
          if (w_tick) begin
            r_state <= ST_PUBLISH;
            r_busy  <= 1'b0;
          end
        end
        ST_PUBLISH: begin
`ifdef TC_ADC_AVG_EN
          if (r_avg_cnt == c_avg_last) begin
            r_code    <= TC_CODE_W'(w_sum >> AVG_LOG2);
            r_valid   <= 1'b1;
            r_acc     <= '0;
            r_avg_cnt <= '0;
          end else begin
            r_acc     <= w_sum;
            r_avg_cnt <= r_avg_cnt + 1'b1;
          end
`else
          r_code  <= r_shift;
          r_valid <= 1'b1;
`endif
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_csn   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_spi_csn  = r_csn;
  assign o_spi_sclk = w_sclk;
  assign o_code     = r_code;
  assign o_valid    = r_valid;
  assign o_busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_tc_adc_spi.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Module : tb_tc_adc_spi                                            |
// | Brief  : Scoreboard bench for tc_adc_spi with SPI ADC models      |
// | Rev    : 1.0                                                      |
// +------------------------------------------------------------------+
module tb_tc_adc_spi;

  localparam int CLK_DIV = 2;
  localparam int SP_A    = 200;
  localparam int SP_B    = 60;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_a, en_b;
  logic       csn_a, sclk_a, valid_a, busy_a;
  logic       csn_b, sclk_b, valid_b, busy_b;
  logic       miso_a = 1'b0;
  logic       miso_b = 1'b0;
  logic [9:0] code_a, code_b;

  always #5 clk = ~clk;

  tc_adc_spi #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SP_A), .AVG_LOG2(2)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_a), .o_spi_csn(csn_a), .o_spi_sclk(sclk_a),
    .i_spi_miso(miso_a), .o_code(code_a), .o_valid(valid_a), .o_busy(busy_a)
  );

  tc_adc_spi #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SP_B), .AVG_LOG2(2)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_b), .o_spi_csn(csn_b), .o_spi_sclk(sclk_b),
    .i_spi_miso(miso_b), .o_code(code_b), .o_valid(valid_b), .o_busy(busy_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ADC model A: drives bit 15 on CSN fall, next bit on each SCLK fall.
  logic [9:0]  mq_a[$];
  logic [9:0]  last_a = 10'd0;
  logic [15:0] frm_a  = 16'd0;
  int          bi_a   = 0;

  always @(negedge csn_a) begin
    if (mq_a.size() > 0) last_a = mq_a.pop_front();
    frm_a  = {3'b101, last_a, 3'b011};
    bi_a   = 15;
    miso_a = frm_a[15];
  end

  always @(negedge sclk_a) begin
    if (!csn_a && bi_a > 0) begin
      bi_a--;
      miso_a = frm_a[bi_a];
    end
  end

  // ADC model B: fixed code 0x3A6.
  logic [15:0] frm_b = 16'd0;
  int          bi_b  = 0;

  always @(negedge csn_b) begin
    frm_b  = {3'b110, 10'h3A6, 3'b001};
    bi_b   = 15;
    miso_b = frm_b[15];
  end

  always @(negedge sclk_b) begin
    if (!csn_b && bi_b > 0) begin
      bi_b--;
      miso_b = frm_b[bi_b];
    end
  end

  // Monitor A: scoreboard pop on o_valid plus frame timing capture.
  logic [9:0] exp_q[$];
  logic [9:0] exp_v;
  int   vcyc_a[$];
  int   falls_a = 0, rises_a = 0, valids_a = 0;
  int   fall_cyc_a = 0, csnrise_cyc_a = 0, valid_cyc_a = 0;
  int   sclk_rises_a = 0, frame_rises_a = 0;
  logic p_csn_a = 1'b1, p_sclk_a = 1'b0;

  always @(negedge clk) begin
    if (!csn_a && p_csn_a) begin
      falls_a++;
      fall_cyc_a   = cyc;
      sclk_rises_a = 0;
    end
    if (csn_a && !p_csn_a) begin
      rises_a++;
      csnrise_cyc_a = cyc;
      frame_rises_a = sclk_rises_a;
    end
    if (sclk_a && !p_sclk_a) sclk_rises_a++;
    if (valid_a) begin
      valids_a++;
      valid_cyc_a = cyc;
      vcyc_a.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid_a: o_valid with o_code=0x%0h, no result expected", code_a);
      end else begin
        exp_v = exp_q.pop_front();
        check("code_a", int'(code_a), int'(exp_v));
      end
    end
    p_csn_a  = csn_a;
    p_sclk_a = sclk_a;
  end

  // Monitor B: fixed code and CSN-fall to previous-valid gap.
  int   falls_b = 0, valids_b = 0, valid_cyc_b = 0;
  int   gaps_b[$];
  logic p_csn_b = 1'b1;

  always @(negedge clk) begin
    if (!csn_b && p_csn_b) begin
      falls_b++;
      if (valids_b > 0) gaps_b.push_back(cyc - valid_cyc_b);
    end
    if (valid_b) begin
      valids_b++;
      valid_cyc_b = cyc;
      check("code_b", int'(code_b), 'h3A6);
    end
    p_csn_b = csn_b;
  end

  function automatic int cnt_of(input int which);
    case (which)
      0:       return valids_a;
      1:       return falls_a;
      2:       return rises_a;
      3:       return valids_b;
      default: return 0;
    endcase
  endfunction

  task automatic wait_for(input int which, input int target, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (cnt_of(which) >= target) return;
      @(posedge clk);
    end
    if (cnt_of(which) < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_%s: count %0d, required %0d", name, cnt_of(which), target);
    end
  endtask

  // Returns #1 after the posedge on which the n-th SCLK rise of model A appears.
  task automatic wait_sclk_rises(input int n, input int budget);
    int   r;
    logic p;
    r = 0;
    p = sclk_a;
    for (int i = 0; i < budget && r < n; i++) begin
      @(posedge clk);
      #1;
      if (sclk_a && !p) r++;
      p = sclk_a;
    end
    if (r < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_sclk_rises: saw %0d, required %0d", r, n);
    end
  endtask

  int f_save;

  initial begin
    rst_n = 1'b0;
    en_a  = 1'b0;
    en_b  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("reset_csn",   int'(csn_a),   1);
    check("reset_sclk",  int'(sclk_a),  0);
    check("reset_code",  int'(code_a),  0);
    check("reset_valid", int'(valid_a), 0);
    check("reset_busy",  int'(busy_a),  0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef TC_ADC_AVG_EN
    // Four frames averaged: (100+101+102+103)>>2 = 101, one pulse after frame 4.
    mq_a.push_back(10'd100);
    mq_a.push_back(10'd101);
    mq_a.push_back(10'd102);
    mq_a.push_back(10'd103);
    exp_q.push_back(10'd101);
    en_a = 1'b1;
    wait_for(1, 4, 1200, "avg_falls");
    wait_for(0, 1, 200, "avg_valid");
    check("avg_valid_latency", valid_cyc_a - fall_cyc_a, 71);
    check("avg_frames_before_valid", falls_a, 4);
    repeat (50) @(posedge clk);
    en_a = 1'b0;
`else
    // Single frame 0x2A5: CSN low 68 cycles, 16 rises, valid 71 after CSN fall.
    mq_a.push_back(10'h2A5);
    exp_q.push_back(10'h2A5);
    en_a = 1'b1;
    wait_for(1, 1, 400, "t1_fall");
    wait_for(2, 1, 200, "t1_csn_rise");
    check("t1_csn_low_cycles", csnrise_cyc_a - fall_cyc_a, 68);
    check("t1_sclk_rises", frame_rises_a, 16);
    wait_for(0, 1, 200, "t1_valid");
    check("t1_valid_latency", valid_cyc_a - fall_cyc_a, 71);

    // Consecutive frames with extreme and alternating codes, 200 cycles apart.
    mq_a.push_back(10'h000);
    mq_a.push_back(10'h3FF);
    mq_a.push_back(10'h155);
    exp_q.push_back(10'h000);
    exp_q.push_back(10'h3FF);
    exp_q.push_back(10'h155);
    wait_for(0, 4, 800, "t2_valids");
    for (int k = 1; k < 4; k++) check("t2_valid_spacing", vcyc_a[k] - vcyc_a[k-1], 200);

    // i_en drops at rise 5: frame still publishes, then no new frame.
    mq_a.push_back(10'h0F0);
    exp_q.push_back(10'h0F0);
    wait_for(1, 5, 400, "t5_fall");
    wait_sclk_rises(5, 200);
    en_a = 1'b0;
    wait_for(0, 5, 200, "t5_valid");
    f_save = falls_a;
    repeat (1000) @(posedge clk);
    check("t5_no_new_frame", falls_a - f_save, 0);

    // Reset at rise 8: outputs clear at once; the aborted frame never publishes.
    mq_a.push_back(10'h1C3);
    en_a = 1'b1;
    wait_for(1, 6, 400, "t4_fall");
    wait_sclk_rises(8, 200);
    rst_n = 1'b0;
    #1;
    check("t4_rst_csn",   int'(csn_a),   1);
    check("t4_rst_sclk",  int'(sclk_a),  0);
    check("t4_rst_busy",  int'(busy_a),  0);
    check("t4_rst_code",  int'(code_a),  0);
    check("t4_rst_valid", int'(valid_a), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mq_a.push_back(10'h2DB);
    exp_q.push_back(10'h2DB);
    wait_for(1, 7, 400, "t4_refall");
    check("t4_code_held_zero", int'(code_a), 0);
    wait_for(0, 6, 200, "t4_valid");
    en_a = 1'b0;

    // Short period: timer expires mid-frame, next CSN fall 1 cycle after the valid.
    en_b = 1'b1;
    wait_for(3, 3, 600, "t6_valids");
    en_b = 1'b0;
    check("t6_gap0", (gaps_b.size() > 0) ? gaps_b[0] : -1, 1);
    check("t6_gap1", (gaps_b.size() > 1) ? gaps_b[1] : -1, 1);
`endif

    repeat (20) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
